// File: rtl/div_pkg.sv
// Shared types and constants for the arbitrated iterative divider.
package div_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DBZ_REM   = 1;
endpackage

// File: rtl/div_core.sv
// Iterative unsigned restoring divider with a single-cycle path for trivial operands.
module div_core
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);
  localparam int CW = $clog2(WIDTH);

  logic             busy_r;
  logic             fast_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] den_r;
  logic [WIDTH:0]   rem_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;

  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   rem_next_s;
  logic             bit_s;
  logic             done_s;
  logic [WIDTH-1:0] fast_q_s;
  logic [WIDTH-1:0] fast_r_s;
  logic             fast_z_s;

  // One restoring step: shift in the next dividend bit, trial subtract, keep or restore
  always_comb begin
    shift_s = (rem_r << 1) | {{WIDTH{1'b0}}, q_r[WIDTH-1]};
    trial_s = shift_s - {1'b0, den_r};
    if (trial_s[WIDTH]) begin
      bit_s      = 1'b0;
      rem_next_s = shift_s;
    end else begin
      bit_s      = 1'b1;
      rem_next_s = trial_s;
    end
    done_s = busy_r && (fast_r || (count_r == CW'(WIDTH - 1)));
  end

  // Trivial-operand results; q_r still holds the unshifted dividend on the fast path
  always_comb begin
    if (den_r == WIDTH'(0)) begin
      fast_q_s = WIDTH'(0);
      fast_r_s = WIDTH'(DBZ_REM);
      fast_z_s = 1'b1;
    end else if (den_r == q_r) begin
      fast_q_s = WIDTH'(1);
      fast_r_s = WIDTH'(0);
      fast_z_s = 1'b0;
    end else begin
      fast_q_s = WIDTH'(0);
      fast_r_s = q_r;
      fast_z_s = 1'b0;
    end
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r      <= 1'b0;
      fast_r      <= 1'b0;
      q_r         <= WIDTH'(0);
      den_r       <= WIDTH'(0);
      rem_r       <= {(WIDTH + 1){1'b0}};
      count_r     <= CW'(0);
      quotient_r  <= WIDTH'(0);
      remainder_r <= WIDTH'(0);
      dbz_r       <= 1'b0;
    end else if (start && !busy_r) begin
      busy_r  <= 1'b1;
      fast_r  <= (divisor == WIDTH'(0)) || (divisor >= dividend);
      q_r     <= dividend;
      den_r   <= divisor;
      rem_r   <= {(WIDTH + 1){1'b0}};
      count_r <= CW'(0);
    end else if (done_s) begin
      busy_r <= 1'b0;
      if (fast_r) begin
        quotient_r  <= fast_q_s;
        remainder_r <= fast_r_s;
        dbz_r       <= fast_z_s;
      end else begin
        quotient_r  <= {q_r[WIDTH-2:0], bit_s};
        remainder_r <= rem_next_s[WIDTH-1:0];
        dbz_r       <= 1'b0;
      end
    end else if (busy_r) begin
      q_r     <= {q_r[WIDTH-2:0], bit_s};
      rem_r   <= rem_next_s;
      count_r <= count_r + CW'(1);
    end
  end

  assign busy      = busy_r;
  assign done      = done_s;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign dbz       = dbz_r;
endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbitration of two requesters onto one shared div_core, with
// a valid/ready response handshake.
module div_arbiter
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  rsp_dbz
);
  state_t           state_r;
  state_t           state_s;
  logic             last_r;
  logic             rsp_id_r;
  logic             rsp_valid_r;
  logic [1:0]       grant_s;
  logic             sel_s;
  logic             accept_s;
  logic [WIDTH-1:0] op_dividend_s;
  logic [WIDTH-1:0] op_divisor_s;
  logic             core_busy_s;
  logic             core_done_s;

  // Grant the only valid port, or the one not served last when both are valid
  always_comb begin
    case (req_valid[1:0])
      2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      default: grant_s = 2'b00;
    endcase
    sel_s = grant_s[1];
    if ((state_r == IDLE) && !rst && !core_busy_s) begin
      req_ready = NREQ'(grant_s);
    end else begin
      req_ready = {NREQ{1'b0}};
    end
    accept_s      = |(req_valid[1:0] & req_ready[1:0]);
    op_dividend_s = sel_s ? req_dividend[2*WIDTH-1:WIDTH] : req_dividend[WIDTH-1:0];
    op_divisor_s  = sel_s ? req_divisor[2*WIDTH-1:WIDTH]  : req_divisor[WIDTH-1:0];
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (core_done_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, round-robin pointer and response bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      last_r      <= 1'b1;
      rsp_id_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      rsp_valid_r <= (state_s == DONE);
      if (accept_s) begin
        last_r   <= sel_s;
        rsp_id_r <= sel_s;
      end
    end
  end

  div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (accept_s),
    .dividend (op_dividend_s),
    .divisor  (op_divisor_s),
    .busy     (core_busy_s),
    .done     (core_done_s),
    .quotient (rsp_quotient),
    .remainder(rsp_remainder),
    .dbz      (rsp_dbz)
  );

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed cases, round-robin, backpressure,
// mid-operation reset and randomized traffic against an arithmetic reference.
module tb_div_arbiter;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_dividend;
  logic [2*W-1:0] req_divisor;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W-1:0]   rsp_quotient;
  logic [W-1:0]   rsp_remainder;
  logic           rsp_dbz;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_arbiter #(.WIDTH(W), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz)
  );

  // Reference: plain arithmetic, dbz convention, latency 1 when divisor==0 or divisor>=dividend
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output int l);
    if (b == 0) begin
      q = 0; r = 1; z = 1'b1; l = 1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
      l = (b >= a) ? 1 : W;
    end
  endfunction

  // Present a request on port p and wait until it is accepted; returns at +1 after the accept edge
  task automatic issue(input int p, input logic [W-1:0] a, input logic [W-1:0] b, output logic acc);
    acc = 1'b0;
    req_dividend[p*W +: W] = a;
    req_divisor[p*W +: W]  = b;
    req_valid[p] = 1'b1;
    #1;
    for (int i = 0; i < 100 && !acc; i++) begin
      if (req_ready[p] === 1'b1) begin
        acc = 1'b1;
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
      end else begin
        @(posedge clk); #2;
      end
    end
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_rsp(output int l);
    l = 0;
    while (rsp_valid !== 1'b1 && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic handshake;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    req_dividend = '0; req_divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id); end
    checks++; if (rsp_quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %0h expected 0", rsp_quotient); end
    checks++; if (rsp_remainder !== '0) begin errors++; $display("FAIL reset_remainder: got %0h expected 0", rsp_remainder); end
    checks++; if (rsp_dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", rsp_dbz); end
    req_valid = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    int          dp[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    logic [W-1:0] da[8] = '{32'd156, 32'd156, 32'hFFFFFFFF, 32'd0, 32'd156, 32'd5, 32'd1132456, 32'd100};
    logic [W-1:0] db[8] = '{32'd23, 32'd0, 32'd1, 32'd1, 32'd156, 32'd7, 32'd231352, 32'd7};
    logic [W-1:0] eq, er;
    logic ez, acc;
    int el, l;
    for (int i = 0; i < 8; i++) begin
      ref_div(da[i], db[i], eq, er, ez, el);
      issue(dp[i], da[i], db[i], acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL dir_accept[%0d]: got %b expected 1", i, acc); end
      wait_rsp(l);
      checks++; if (l != el) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, l, el); end
      checks++; if (rsp_quotient !== eq) begin errors++; $display("FAIL dir_quotient[%0d]: got %0h expected %0h", i, rsp_quotient, eq); end
      checks++; if (rsp_remainder !== er) begin errors++; $display("FAIL dir_remainder[%0d]: got %0h expected %0h", i, rsp_remainder, er); end
      checks++; if (rsp_dbz !== ez) begin errors++; $display("FAIL dir_dbz[%0d]: got %b expected %b", i, rsp_dbz, ez); end
      checks++; if (rsp_id !== dp[i][0]) begin errors++; $display("FAIL dir_id[%0d]: got %b expected %b", i, rsp_id, dp[i][0]); end
      handshake();
    end
  endtask

  task automatic test_round_robin;
    logic [W-1:0] a[2] = '{32'd1132456, 32'd1};
    logic [W-1:0] b[2] = '{32'd231352, 32'd10421};
    logic [W-1:0] eq, er;
    logic ez;
    int el, l, last_m, g;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    req_dividend = {a[1], a[0]}; req_divisor = {b[1], b[0]};
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_first_grant: got %b expected 01", req_ready); end
    last_m = 1;
    for (int k = 0; k < 4; k++) begin
      g = (last_m == 1) ? 0 : 1;
      last_m = g;
      ref_div(a[g], b[g], eq, er, ez, el);
      wait_rsp(l);
      checks++; if (l >= 100) begin errors++; $display("FAIL rr_timeout[%0d]: got %0d expected <100", k, l); end
      checks++; if (rsp_id !== g[0]) begin errors++; $display("FAIL rr_id[%0d]: got %b expected %b", k, rsp_id, g[0]); end
      checks++; if (rsp_quotient !== eq) begin errors++; $display("FAIL rr_quotient[%0d]: got %0h expected %0h", k, rsp_quotient, eq); end
      checks++; if (rsp_remainder !== er) begin errors++; $display("FAIL rr_remainder[%0d]: got %0h expected %0h", k, rsp_remainder, er); end
      handshake();
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic acc;
    int l;
    issue(0, 32'd100, 32'd7, acc);
    wait_rsp(l);
    req_dividend[W +: W] = 32'd50; req_divisor[W +: W] = 32'd5;
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, rsp_valid); end
      checks++; if (rsp_quotient !== 32'd14) begin errors++; $display("FAIL bp_quotient[%0d]: got %0h expected e", c, rsp_quotient); end
      checks++; if (rsp_remainder !== 32'd2) begin errors++; $display("FAIL bp_remainder[%0d]: got %0h expected 2", c, rsp_remainder); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 00", c, req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_hs_cycle_ready: got %b expected 00", req_ready); end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_resume_grant: got %b expected 10", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(l);
    checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL bp_next_id: got %b expected 1", rsp_id); end
    checks++; if (rsp_quotient !== 32'd10) begin errors++; $display("FAIL bp_next_quotient: got %0h expected a", rsp_quotient); end
    handshake();
  endtask

  task automatic test_reset_mid_calc;
    logic acc;
    int l, seen;
    issue(1, 32'd156, 32'd23, acc);
    repeat (10) @(posedge clk);
    #1;
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL mid_rst_id: got %b expected 0", rsp_id); end
    checks++; if (rsp_quotient !== '0) begin errors++; $display("FAIL mid_rst_quotient: got %0h expected 0", rsp_quotient); end
    checks++; if (rsp_remainder !== '0) begin errors++; $display("FAIL mid_rst_remainder: got %0h expected 0", rsp_remainder); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_rst_ready: got %b expected 00", req_ready); end
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen = 1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_rst_no_rsp: got %0d expected 0", seen); end
    issue(0, 32'd156, 32'd23, acc);
    wait_rsp(l);
    checks++; if (l != W) begin errors++; $display("FAIL post_rst_latency: got %0d expected %0d", l, W); end
    checks++; if (rsp_quotient !== 32'd6) begin errors++; $display("FAIL post_rst_quotient: got %0h expected 6", rsp_quotient); end
    checks++; if (rsp_remainder !== 32'd18) begin errors++; $display("FAIL post_rst_remainder: got %0h expected 12", rsp_remainder); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL post_rst_id: got %b expected 0", rsp_id); end
    handshake();
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, eq, er;
    logic ez, acc;
    int p, el, l;
    for (int n = 0; n < 40; n++) begin
      p = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 0;
        1:       b = a;
        2:       b = $urandom_range(1, 255);
        3:       b = $urandom;
        default: b = a + $urandom_range(1, 10);
      endcase
      ref_div(a, b, eq, er, ez, el);
      issue(p, a, b, acc);
      wait_rsp(l);
      checks++; if (l != el) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, l, el); end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      checks++; if (rsp_quotient !== eq) begin errors++; $display("FAIL rnd_quotient[%0d] %0h/%0h: got %0h expected %0h", n, a, b, rsp_quotient, eq); end
      checks++; if (rsp_remainder !== er) begin errors++; $display("FAIL rnd_remainder[%0d] %0h/%0h: got %0h expected %0h", n, a, b, rsp_remainder, er); end
      checks++; if (rsp_dbz !== ez) begin errors++; $display("FAIL rnd_dbz[%0d]: got %b expected %b", n, rsp_dbz, ez); end
      checks++; if (rsp_id !== p[0]) begin errors++; $display("FAIL rnd_id[%0d]: got %b expected %b", n, rsp_id, p[0]); end
      handshake();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
